// File: rtl/wta_subpixel_prep.sv
// wta_subpixel_prep
// Streaming winner-take-all stage feeding the sub-pixel divider. Takes one
// aggregated matching cost per accepted cycle for disparities 0..DMAX-1,
// tracks the minimum and its two neighbour costs, and emits the parabola-fit
// numerator/denominator/sign one enabled cycle after the pixel's last sample.
// The integer disparity is also delayed by the divider latency so that the
// integer and fractional parts reach the downstream merge together.
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset, overrides clken
//   clken               global enable; low freezes every register
//   cost_valid          a cost sample is present
//   cost_first          marks the sample for disparity 0 (starts a pixel)
//   cost[CW-1:0]        unsigned cost
//   x[10:0]             |cl - cr|, divider dividend
//   d[10:0]             cl + cr - 2*minc, divider divisor (saturated)
//   f                   1 when cl < cr
//   validout            one enabled-cycle strobe qualifying x/d/f/disp_int
//   disp_int[DW-1:0]    integer winning disparity
//   disp_aligned        disp_int delayed by DIV_LAT enabled cycles
//   disp_aligned_valid  validout delayed by DIV_LAT enabled cycles
module wta_subpixel_prep #(
    parameter int DMAX    = 64,
    parameter int DW      = 6,
    parameter int CW      = 10,
    parameter int DIV_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          cost_valid,
    input  logic          cost_first,
    input  logic [CW-1:0] cost,
    output logic [10:0]   x,
    output logic [10:0]   d,
    output logic          f,
    output logic          validout,
    output logic [DW-1:0] disp_int,
    output logic [DW-1:0] disp_aligned,
    output logic          disp_aligned_valid
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t                    state_r;
    logic [DW-1:0]             idx_r;
    logic [DW-1:0]             mini_r;
    logic [CW-1:0]             minc_r;
    logic [CW-1:0]             cl_r;
    logic [CW-1:0]             cr_r;
    logic [CW-1:0]             prev_r;
    logic                      need_right_r;
    logic                      done_r;
    logic [DIV_LAT-1:0]        dlv_r;
    logic [DIV_LAT-1:0][DW-1:0] dld_r;

    logic [DW-1:0] idx_inc_s;
    logic          is_last_s;
    logic [DW-1:0] mini_n_s;
    logic [CW-1:0] minc_n_s;
    logic [CW-1:0] cl_n_s;
    logic [CW-1:0] cr_n_s;
    logic          need_n_s;
    logic [11:0]   sum_s;
    logic          boundary_s;
    logic [10:0]   x_n_s;
    logic [10:0]   d_n_s;
    logic          f_n_s;

    assign idx_inc_s = idx_r + DW'(1);
    assign is_last_s = (idx_inc_s == DW'(DMAX - 1));

    // Tracking-register update for a continuation (non-first) sample.
    always_comb begin
        minc_n_s = minc_r;
        mini_n_s = mini_r;
        cl_n_s   = cl_r;
        cr_n_s   = cr_r;
        need_n_s = need_right_r;
        if (cost < minc_r) begin
            // strict compare: ties keep the lowest disparity
            minc_n_s = cost;
            mini_n_s = idx_inc_s;
            cl_n_s   = prev_r;
            need_n_s = 1'b1;
        end else if (need_right_r) begin
            cr_n_s   = cost;
            need_n_s = 1'b0;
        end else begin
            cr_n_s   = cr_r;
        end
        // minimum on the last disparity has no right neighbour: mirror it
        if (is_last_s && need_n_s) begin
            cr_n_s = minc_n_s;
        end else begin
            cr_n_s = cr_n_s;
        end
    end

    // Parabola-fit terms from the finished pixel's tracking registers.
    always_comb begin
        // cl and cr are never below minc, so the difference stays non-negative
        sum_s      = 12'(cl_r) + 12'(cr_r) - (12'(minc_r) << 1);
        boundary_s = (mini_r == '0) || (mini_r == DW'(DMAX - 1)) || (sum_s == 12'd0);
        x_n_s      = 11'd0;
        d_n_s      = 11'd1;
        f_n_s      = 1'b0;
        if (boundary_s) begin
            // x=0, d=1 makes the divider return a zero fraction
            x_n_s = 11'd0;
            d_n_s = 11'd1;
            f_n_s = 1'b0;
        end else begin
            x_n_s = (cl_r >= cr_r) ? 11'(cl_r - cr_r) : 11'(cr_r - cl_r);
            d_n_s = (sum_s > 12'd2047) ? 11'd2047 : sum_s[10:0];
            f_n_s = (cl_r < cr_r);
        end
    end

    // Pixel sequencing, minimum tracking, result registers and delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            idx_r        <= '0;
            mini_r       <= '0;
            minc_r       <= '0;
            cl_r         <= '0;
            cr_r         <= '0;
            prev_r       <= '0;
            need_right_r <= 1'b0;
            done_r       <= 1'b0;
            x            <= 11'd0;
            d            <= 11'd0;
            f            <= 1'b0;
            validout     <= 1'b0;
            disp_int     <= '0;
            dlv_r        <= '0;
            dld_r        <= '0;
        end else if (clken) begin
            // result stage reads tracking registers before this edge's update
            if (done_r) begin
                validout <= 1'b1;
                disp_int <= mini_r;
                x        <= x_n_s;
                d        <= d_n_s;
                f        <= f_n_s;
                done_r   <= 1'b0;
            end else begin
                validout <= 1'b0;
            end

            dlv_r[0] <= validout;
            dld_r[0] <= disp_int;
            for (int k = 1; k < DIV_LAT; k++) begin
                dlv_r[k] <= dlv_r[k-1];
                dld_r[k] <= dld_r[k-1];
            end

            if (cost_valid && cost_first) begin
                // a first sample always (re)starts a pixel, abandoning any partial one
                state_r      <= S_ACC;
                idx_r        <= '0;
                minc_r       <= cost;
                mini_r       <= '0;
                cl_r         <= cost;
                prev_r       <= cost;
                need_right_r <= 1'b1;
            end else if (cost_valid && (state_r == S_ACC)) begin
                idx_r        <= idx_inc_s;
                minc_r       <= minc_n_s;
                mini_r       <= mini_n_s;
                cl_r         <= cl_n_s;
                cr_r         <= cr_n_s;
                need_right_r <= need_n_s;
                prev_r       <= cost;
                if (is_last_s) begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b1;
                end else begin
                    state_r <= S_ACC;
                end
            end else begin
                // idle samples without cost_first are dropped
                state_r <= state_r;
            end
        end else begin
            state_r <= state_r;
        end
    end

    assign disp_aligned_valid = dlv_r[DIV_LAT-1];
    assign disp_aligned       = dld_r[DIV_LAT-1];

endmodule

// File: tb/tb_wta_subpixel_prep.sv
// Directed self-checking bench for wta_subpixel_prep.
module tb_wta_subpixel_prep;

    logic        clk;
    logic        rst;
    logic        clken;
    logic        cost_valid;
    logic        cost_first;
    logic [9:0]  cost;
    logic [10:0] x;
    logic [10:0] d;
    logic        f;
    logic        validout;
    logic [5:0]  disp_int;
    logic [5:0]  disp_aligned;
    logic        disp_aligned_valid;

    wta_subpixel_prep dut (
        .clk                (clk),
        .rst                (rst),
        .clken              (clken),
        .cost_valid         (cost_valid),
        .cost_first         (cost_first),
        .cost               (cost),
        .x                  (x),
        .d                  (d),
        .f                  (f),
        .validout           (validout),
        .disp_int           (disp_int),
        .disp_aligned       (disp_aligned),
        .disp_aligned_valid (disp_aligned_valid)
    );

    typedef struct {
        int          cyc;
        logic [10:0] sx;
        logic [10:0] sd;
        logic        sf;
        logic [5:0]  di;
    } strobe_t;

    strobe_t    sq[$];
    strobe_t    aq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0;
    logic [9:0] cv [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe that an enabled edge will consume.
    always @(negedge clk) begin
        strobe_t s;
        if (clken && validout) begin
            s.cyc = cyc; s.sx = x; s.sd = d; s.sf = f; s.di = disp_int;
            sq.push_back(s);
        end
        if (clken && disp_aligned_valid) begin
            s.cyc = cyc; s.sx = 11'd0; s.sd = 11'd0; s.sf = 1'b0; s.di = disp_aligned;
            aq.push_back(s);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fst, input logic [9:0] c, input logic en);
        cost_valid = v;
        cost_first = fst;
        cost       = c;
        clken      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 10'd0, 1'b1);
    endtask

    task automatic fill(input logic [9:0] base);
        for (int i = 0; i < 64; i++) cv[i] = base;
    endtask

    // Send samples 0..n-1; optionally hold sample gap_at with clken low first.
    task automatic send_pixel(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (gap_len) drive(1'b1, (i == 0), cv[i], 1'b0);
            drive(1'b1, (i == 0), cv[i], 1'b1);
        end
    endtask

    task automatic check_one(input string tag, input int lat, input int ex, input int ed,
                             input int ef, input int edi);
        check({tag, "_count"}, sq.size(), 1);
        if (sq.size() > 0) begin
            check({tag, "_lat"}, sq[0].cyc - t0, lat);
            check({tag, "_x"},   sq[0].sx, ex);
            check({tag, "_d"},   sq[0].sd, ed);
            check({tag, "_f"},   sq[0].sf, ef);
            check({tag, "_disp"}, sq[0].di, edi);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_d"}, d, 0);
        check({tag, "_f"}, f, 0);
        check({tag, "_validout"}, validout, 0);
        check({tag, "_disp_int"}, disp_int, 0);
        check({tag, "_disp_aligned"}, disp_aligned, 0);
        check({tag, "_aligned_valid"}, disp_aligned_valid, 0);
    endtask

    initial begin
        rst = 1'b1; clken = 1'b0; cost_valid = 1'b0; cost_first = 1'b0; cost = 10'd0;
        // reset must take effect even with clken low
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // interior minimum
        fill(10'd100); cv[9] = 10'd60; cv[10] = 10'd40; cv[11] = 10'd80;
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("interior", 65, 20, 60, 1, 10);
        check("aligned_count", aq.size(), 1);
        if (aq.size() > 0) begin
            check("aligned_lat", aq[0].cyc - t0, 68);
            check("aligned_disp", aq[0].di, 10);
        end
        check("hold_x", x, 20);
        check("hold_disp", disp_int, 10);

        // ties keep the lowest index
        fill(10'd100); cv[20] = 10'd50; cv[30] = 10'd50;
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("tie", 65, 0, 100, 0, 20);

        // minimum at disparity 0
        fill(10'd100); cv[0] = 10'd5;
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("edge0", 65, 0, 1, 0, 0);

        // flat curve
        fill(10'd7);
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("flat", 65, 0, 1, 0, 0);

        // minimum at the last disparity
        fill(10'd7); cv[63] = 10'd3;
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("edge63", 65, 0, 1, 0, 63);

        // clken gap of 5 cycles at sample 32
        fill(10'd100); cv[9] = 10'd60; cv[10] = 10'd40; cv[11] = 10'd80;
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, 32, 5); idle(10);
        check_one("gap", 70, 20, 60, 1, 10);
        check("gap_aligned_count", aq.size(), 1);
        if (aq.size() > 0) check("gap_aligned_lat", aq[0].cyc - t0, 73);

        // back-to-back pixels, minima at 10 then 50
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0);
        fill(10'd100); cv[49] = 10'd90; cv[50] = 10'd30; cv[51] = 10'd70;
        send_pixel(64, -1, 0); idle(10);
        check("b2b_count", sq.size(), 2);
        if (sq.size() > 1) begin
            check("b2b_lat0", sq[0].cyc - t0, 65);
            check("b2b_disp0", sq[0].di, 10);
            check("b2b_x0", sq[0].sx, 20);
            check("b2b_lat1", sq[1].cyc - t0, 129);
            check("b2b_disp1", sq[1].di, 50);
            check("b2b_x1", sq[1].sx, 20);
            check("b2b_d1", sq[1].sd, 100);
            check("b2b_f1", sq[1].sf, 0);
        end

        // abort: partial pixel with minimum at 5, then full interior pixel
        fill(10'd100); cv[5] = 10'd1;
        sq.delete(); aq.delete();
        send_pixel(30, -1, 0);
        fill(10'd100); cv[9] = 10'd60; cv[10] = 10'd40; cv[11] = 10'd80;
        t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("abort", 65, 20, 60, 1, 10);

        // reset mid-pixel, then stray non-first samples, then a full pixel
        fill(10'd100); cv[49] = 10'd90; cv[50] = 10'd30; cv[51] = 10'd70;
        sq.delete(); aq.delete();
        send_pixel(40, -1, 0);
        rst = 1'b1;
        drive(1'b1, 1'b0, cv[40], 1'b1);
        rst = 1'b0;
        check_reset_outputs("midrst");
        for (int i = 41; i < 64; i++) drive(1'b1, 1'b0, cv[i], 1'b1);
        idle(80);
        check("midrst_no_strobe", sq.size(), 0);
        check("midrst_no_aligned", aq.size(), 0);
        sq.delete(); aq.delete(); t0 = cyc;
        send_pixel(64, -1, 0); idle(10);
        check_one("after_rst", 65, 20, 100, 0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
